// File: rtl/i2c_ascii_fmt_pkg.sv
// i2c_ascii_fmt_pkg
//   Shared definitions for the I2C-event-to-ASCII formatter: event type
//   codes, the ASCII characters it emits, and the formatter FSM encoding.
//   No ports; imported by the formatter top.
package i2c_ascii_fmt_pkg;

    localparam logic [1:0] EVT_START   = 2'd0;
    localparam logic [1:0] EVT_RESTART = 2'd1;
    localparam logic [1:0] EVT_DATA    = 2'd2;
    localparam logic [1:0] EVT_STOP    = 2'd3;

    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_BANG  = 8'h21;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EMIT_BANG,
        ST_EMIT_S,
        ST_EMIT_R,
        ST_EMIT_HI,
        ST_EMIT_LO,
        ST_EMIT_ACK,
        ST_EMIT_SP,
        ST_EMIT_P,
        ST_EMIT_CR,
        ST_EMIT_LF
    } state_e;

    // First character state of each event type.
    function automatic state_e first_state(input logic [1:0] evt_type);
        case (evt_type)
            EVT_START:   return ST_EMIT_S;
            EVT_RESTART: return ST_EMIT_R;
            EVT_DATA:    return ST_EMIT_HI;
            default:     return ST_EMIT_P;
        endcase
    endfunction

endpackage

// File: rtl/i2c_ascii_fmt_if.sv
// i2c_ascii_fmt_if
//   Bus bundle around the formatter: the event strobe bus coming from the
//   I2C monitor and the write port towards the UART TX FIFO.
//   master: event source / FIFO side (drives events and full flag).
//   slave : the formatter (drives write enable and character).
interface i2c_ascii_fmt_if;
    logic       evt_stb;
    logic [1:0] evt_type;
    logic [7:0] evt_data;
    logic       evt_ack;
    logic       full;
    logic       wen;
    logic [7:0] data;

    modport master (output evt_stb, evt_type, evt_data, evt_ack, full,
                    input  wen, data);
    modport slave  (input  evt_stb, evt_type, evt_data, evt_ack, full,
                    output wen, data);
endinterface

// File: rtl/i2c_hex_nibble.sv
// i2c_hex_nibble
//   Converts a 4-bit nibble into its ASCII hex digit.
//   nib_i : nibble value
//   asc_o : ASCII character ('0'-'9', then 'A'-'F' or 'a'-'f' per HEX_UPPER)
module i2c_hex_nibble #(
    parameter bit HEX_UPPER = 1'b1
) (
    input  logic [3:0] nib_i,
    output logic [7:0] asc_o
);
    localparam logic [7:0] ALPHA_BASE = HEX_UPPER ? 8'h41 : 8'h61;

    always_comb begin
        if (nib_i < 4'd10) begin
            asc_o = 8'h30 + {4'h0, nib_i};
        end else begin
            asc_o = ALPHA_BASE + {4'h0, nib_i} - 8'd10;
        end
    end
endmodule

// File: rtl/i2c_ascii_fmt.sv
// i2c_ascii_fmt
//   Turns I2C monitor events into printable ASCII for the UART TX FIFO.
//   One event of buffering (hold register); events arriving while it is
//   occupied are dropped, flagged sticky on o_ovf and reported in-band as
//   a '!' ahead of the next emitted event.
//   i_clk, i_res_n : clock, async active-low reset
//   bus            : event strobe/type/data/ack in, FIFO full in,
//                    write enable / character out
//   o_ovf          : sticky drop flag, cleared by i_ovf_clr (set wins)
//   o_busy         : FSM active or hold register occupied
module i2c_ascii_fmt
    import i2c_ascii_fmt_pkg::*;
#(
    parameter bit HEX_UPPER = 1'b1,
    parameter bit EOL_CRLF  = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_res_n,
    i2c_ascii_fmt_if.slave bus,
    output logic           o_ovf,
    input  logic           i_ovf_clr,
    output logic           o_busy
);
    state_e     state_q;
    logic       hold_vld_q, hold_vld_d;
    logic [1:0] hold_type_q;
    logic [7:0] hold_data_q;
    logic       hold_ack_q;
    logic [1:0] wrk_type_q;
    logic [7:0] wrk_data_q;
    logic       wrk_ack_q;
    logic       bang_q, bang_d;
    logic       ovf_q, ovf_d;
    logic       load, take, drop, adv;
    logic [7:0] hex_hi, hex_lo;

    // Loading from the hold register frees it in the same cycle, so a
    // coincident strobe is captured rather than dropped.
    assign load = (state_q == ST_IDLE) && hold_vld_q;
    assign take = bus.evt_stb && (!hold_vld_q || load);
    assign drop = bus.evt_stb && hold_vld_q && !load;
    assign adv  = (state_q != ST_IDLE) && !bus.full;

    always_comb begin
        hold_vld_d = hold_vld_q;
        if (take) begin
            hold_vld_d = 1'b1;
        end else if (load) begin
            hold_vld_d = 1'b0;
        end
        bang_d = bang_q;
        if (drop) begin
            bang_d = 1'b1;
        end else if (load) begin
            bang_d = 1'b0;
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            hold_vld_q <= 1'b0;
            bang_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
            bang_q     <= bang_d;
            ovf_q      <= ovf_d;
        end
    end

    // Event payload registers need no reset: they are only read when the
    // matching valid/state says they hold a captured event.
    always_ff @(posedge i_clk) begin
        if (take) begin
            hold_type_q <= bus.evt_type;
            hold_data_q <= bus.evt_data;
            hold_ack_q  <= bus.evt_ack;
        end
        if (load) begin
            wrk_type_q <= hold_type_q;
            wrk_data_q <= hold_data_q;
            wrk_ack_q  <= hold_ack_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (load) state_q <= bang_q ? ST_EMIT_BANG : first_state(hold_type_q);
                ST_EMIT_BANG: if (adv)  state_q <= first_state(wrk_type_q);
                ST_EMIT_HI:   if (adv)  state_q <= ST_EMIT_LO;
                ST_EMIT_LO:   if (adv)  state_q <= ST_EMIT_ACK;
                ST_EMIT_ACK:  if (adv)  state_q <= ST_EMIT_SP;
                ST_EMIT_P:    if (adv)  state_q <= EOL_CRLF ? ST_EMIT_CR : ST_EMIT_LF;
                ST_EMIT_CR:   if (adv)  state_q <= ST_EMIT_LF;
                default:      if (adv)  state_q <= ST_IDLE;
            endcase
        end
    end

    i2c_hex_nibble #(.HEX_UPPER(HEX_UPPER)) u_hex_hi (
        .nib_i (wrk_data_q[7:4]),
        .asc_o (hex_hi)
    );

    i2c_hex_nibble #(.HEX_UPPER(HEX_UPPER)) u_hex_lo (
        .nib_i (wrk_data_q[3:0]),
        .asc_o (hex_lo)
    );

    always_comb begin
        bus.data = 8'h00;
        case (state_q)
            ST_EMIT_BANG: bus.data = ASC_BANG;
            ST_EMIT_S:    bus.data = ASC_S;
            ST_EMIT_R:    bus.data = ASC_R;
            ST_EMIT_HI:   bus.data = hex_hi;
            ST_EMIT_LO:   bus.data = hex_lo;
            ST_EMIT_ACK:  bus.data = wrk_ack_q ? ASC_MINUS : ASC_PLUS;
            ST_EMIT_SP:   bus.data = ASC_SP;
            ST_EMIT_P:    bus.data = ASC_P;
            ST_EMIT_CR:   bus.data = ASC_CR;
            ST_EMIT_LF:   bus.data = ASC_LF;
            default:      bus.data = 8'h00;
        endcase
    end

    assign bus.wen = adv;
    assign o_ovf   = ovf_q;
    assign o_busy  = (state_q != ST_IDLE) || hold_vld_q;
endmodule
